// File: rtl/ase_pkg.sv
// Shared CCI-P MMIO types, CSR map indices, ERR_STATUS layout and length codes
// used by the MMIO responder and its CSR bank.
package ase_pkg;

    localparam logic [1:0] LEN_4B  = 2'b00;
    localparam logic [1:0] LEN_8B  = 2'b01;
    localparam logic [1:0] LEN_64B = 2'b10;

    localparam int CSR_DFH      = 0;
    localparam int CSR_AFU_ID_L = 1;
    localparam int CSR_AFU_ID_H = 2;
    localparam int CSR_ERR      = 3;
    localparam int CSR_RW_FIRST = 4;

    typedef struct packed {
        logic [30:0] rsvd;
        logic        proto;
        logic [15:0] unmapped;
        logic [15:0] unsup;
    } t_err_status;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

endpackage

// File: rtl/ccip_mmio_csr_bank.sv
// CSR storage: read-only identity registers, ERR_STATUS counters and RW CSRs,
// with MMIO-over-hardware write arbitration.
module ccip_mmio_csr_bank
    import ase_pkg::*;
#(
    parameter int          NUM_CSR   = 16,
    parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_0000,
    parameter logic [63:0] AFU_ID_L  = 64'h0,
    parameter logic [63:0] AFU_ID_H  = 64'h0
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_mmio_wr_en,
    input  logic [5:0]           i_mmio_wr_idx,
    input  logic                 i_mmio_wr_upper,
    input  logic                 i_mmio_wr_len4,
    input  logic [63:0]          i_mmio_wr_data,
    input  logic                 i_hw_wr_en,
    input  logic [5:0]           i_hw_wr_idx,
    input  logic [63:0]          i_hw_wr_data,
    input  logic                 i_inc_unsup,
    input  logic                 i_inc_unmapped,
    input  logic                 i_set_proto,
    output logic [NUM_CSR*64-1:0] o_csr_q
);

    logic [63:0] r_rw [CSR_RW_FIRST:NUM_CSR-1];
    logic [15:0] r_unsup;
    logic [15:0] r_unmapped;
    logic        r_proto;
    logic        w_hw_blocked;
    logic        w_err_clr;
    t_err_status w_err;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_hw_blocked = i_mmio_wr_en && (i_mmio_wr_idx == i_hw_wr_idx);
    assign w_err_clr    = i_mmio_wr_en && (i_mmio_wr_idx == 6'(CSR_ERR));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = CSR_RW_FIRST; i < NUM_CSR; i++) r_rw[i] <= '0;
            r_unsup    <= '0;
            r_unmapped <= '0;
            r_proto    <= 1'b0;
        end else begin
            for (int i = CSR_RW_FIRST; i < NUM_CSR; i++) begin
                if (i_hw_wr_en && !w_hw_blocked && i_hw_wr_idx == 6'(i))
                    r_rw[i] <= i_hw_wr_data;
                if (i_mmio_wr_en && i_mmio_wr_idx == 6'(i)) begin
                    if (!i_mmio_wr_len4)
                        r_rw[i] <= i_mmio_wr_data;
                    else if (i_mmio_wr_upper)
                        r_rw[i][63:32] <= i_mmio_wr_data[31:0];
                    else
                        r_rw[i][31:0] <= i_mmio_wr_data[31:0];
                end
            end
            // A clearing write swallows any error reported in the same cycle.
            if (w_err_clr) begin
                r_unsup    <= '0;
                r_unmapped <= '0;
                r_proto    <= 1'b0;
            end else begin
                if (i_inc_unsup)    r_unsup    <= sat_inc(r_unsup);
                if (i_inc_unmapped) r_unmapped <= sat_inc(r_unmapped);
                if (i_set_proto)    r_proto    <= 1'b1;
            end
        end
    end

    always_comb begin
        w_err          = '0;
        w_err.unsup    = r_unsup;
        w_err.unmapped = r_unmapped;
        w_err.proto    = r_proto;
        o_csr_q        = '0;
        o_csr_q[CSR_DFH*64      +: 64] = DFH_VALUE;
        o_csr_q[CSR_AFU_ID_L*64 +: 64] = AFU_ID_L;
        o_csr_q[CSR_AFU_ID_H*64 +: 64] = AFU_ID_H;
        o_csr_q[CSR_ERR*64      +: 64] = w_err;
        for (int i = CSR_RW_FIRST; i < NUM_CSR; i++) o_csr_q[i*64 +: 64] = r_rw[i];
    end

endmodule

// File: rtl/ccip_mmio_responder.sv
// CCI-P MMIO slave: decodes MMIO requests into a CSR bank and returns read
// responses through a two-stage, fully pipelined response path.
module ccip_mmio_responder
    import ase_pkg::*;
#(
    parameter logic [15:0] MMIO_BASE = 16'h0000,
    parameter int          NUM_CSR   = 16,
    parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_0000,
    parameter logic [63:0] AFU_ID_L  = 64'h0,
    parameter logic [63:0] AFU_ID_H  = 64'h0
)(
    input  logic                  clk,
    input  logic                  SoftReset,
    input  t_if_ccip_Rx           ccip_rx,
    output t_if_ccip_c2_Tx        ccip_c2Tx,
    input  logic                  hw_wr_en,
    input  logic [5:0]            hw_wr_idx,
    input  logic [63:0]           hw_wr_data,
    output logic [NUM_CSR*64-1:0] csr_q
);

    logic [16:0] w_off;
    logic [5:0]  w_idx;
    logic        w_in_range, w_odd, w_unsup, w_rd, w_wr, w_both;
    logic [63:0] w_word_p0, w_rdata_p0;

    logic        r_vld_p0, r_upper_p0, r_len4_p0, r_err_p0;
    logic [8:0]  r_tid_p0;
    logic [5:0]  r_idx_p0;
    logic        r_vld_p1;
    logic [8:0]  r_tid_p1;
    logic [63:0] r_data_p1;

    always_comb begin
        w_off      = {1'b0, ccip_rx.c0.hdr.address} - {1'b0, MMIO_BASE};
        w_in_range = (ccip_rx.c0.hdr.address >= MMIO_BASE) && (w_off < 17'(2*NUM_CSR));
        w_idx      = w_off[6:1];
        w_odd      = w_off[0];
        w_unsup    = (ccip_rx.c0.hdr.length == LEN_64B) || (ccip_rx.c0.hdr.length == 2'b11) ||
                     (ccip_rx.c0.hdr.length == LEN_8B && w_odd);
        w_both     = ccip_rx.c0.mmioRdValid && ccip_rx.c0.mmioWrValid;
        w_rd       = ccip_rx.c0.mmioRdValid && !ccip_rx.c0.mmioWrValid;
        w_wr       = ccip_rx.c0.mmioWrValid && !ccip_rx.c0.mmioRdValid;
    end

    ccip_mmio_csr_bank #(
        .NUM_CSR   (NUM_CSR),
        .DFH_VALUE (DFH_VALUE),
        .AFU_ID_L  (AFU_ID_L),
        .AFU_ID_H  (AFU_ID_H)
    ) u_bank (
        .clk             (clk),
        .rst             (SoftReset),
        .i_mmio_wr_en    (w_wr && w_in_range && !w_unsup),
        .i_mmio_wr_idx   (w_idx),
        .i_mmio_wr_upper (w_odd),
        .i_mmio_wr_len4  (ccip_rx.c0.hdr.length == LEN_4B),
        .i_mmio_wr_data  (ccip_rx.c0.data),
        .i_hw_wr_en      (hw_wr_en),
        .i_hw_wr_idx     (hw_wr_idx),
        .i_hw_wr_data    (hw_wr_data),
        .i_inc_unsup     ((w_rd || w_wr) && w_in_range && w_unsup),
        .i_inc_unmapped  ((w_rd || w_wr) && !w_in_range),
        .i_set_proto     (w_both),
        .o_csr_q         (csr_q)
    );

    // Stage p0 -> p1: CSR lookup happens here, so writes landed one cycle earlier are visible.
    always_comb begin
        w_word_p0 = '0;
        for (int i = 0; i < NUM_CSR; i++)
            if (r_idx_p0 == 6'(i)) w_word_p0 = csr_q[i*64 +: 64];
        if (r_err_p0)
            w_rdata_p0 = '0;
        else if (r_len4_p0)
            w_rdata_p0 = {32'h0, r_upper_p0 ? w_word_p0[63:32] : w_word_p0[31:0]};
        else
            w_rdata_p0 = w_word_p0;
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            r_vld_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_tid_p1  <= '0;
            r_data_p1 <= '0;
        end else begin
            r_vld_p0  <= w_rd;
            r_vld_p1  <= r_vld_p0;
            r_tid_p1  <= r_vld_p0 ? r_tid_p0 : '0;
            r_data_p1 <= r_vld_p0 ? w_rdata_p0 : '0;
        end
        r_tid_p0   <= ccip_rx.c0.hdr.tid;
        r_idx_p0   <= w_idx;
        r_upper_p0 <= w_odd;
        r_len4_p0  <= (ccip_rx.c0.hdr.length == LEN_4B);
        r_err_p0   <= !w_in_range || w_unsup;
    end

    assign ccip_c2Tx = '{hdr: '{tid: r_tid_p1}, mmioRdValid: r_vld_p1, data: r_data_p1};

endmodule

// File: tb/tb_ccip_mmio_responder.sv
// Directed bench for ccip_mmio_responder: a vector table of MMIO accesses plus
// hand sequences for pipelining, write arbitration, protocol violation and reset.
module tb_ccip_mmio_responder;
    import ase_pkg::*;

    localparam int          NCSR = 16;
    localparam logic [63:0] DFH  = 64'h1000_0000_0000_0000;
    localparam logic [63:0] IDL  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] IDH  = 64'hFEDC_BA98_7654_3210;

    logic                clk = 1'b0;
    logic                SoftReset;
    t_if_ccip_Rx         rx;
    t_if_ccip_c2_Tx      tx;
    logic                hw_wr_en;
    logic [5:0]          hw_wr_idx;
    logic [63:0]         hw_wr_data;
    logic [NCSR*64-1:0]  csr_q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [1:0]  len;
        logic [8:0]  tid;
        logic [63:0] data;
    } vec_t;
    vec_t vecs[$];

    ccip_mmio_responder #(
        .MMIO_BASE (16'h0000),
        .NUM_CSR   (NCSR),
        .DFH_VALUE (DFH),
        .AFU_ID_L  (IDL),
        .AFU_ID_H  (IDH)
    ) dut (
        .clk        (clk),
        .SoftReset  (SoftReset),
        .ccip_rx    (rx),
        .ccip_c2Tx  (tx),
        .hw_wr_en   (hw_wr_en),
        .hw_wr_idx  (hw_wr_idx),
        .hw_wr_data (hw_wr_data),
        .csr_q      (csr_q)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] csr(input int n);
        return csr_q[n*64 +: 64];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [1:0] l, input logic [8:0] t, input logic [63:0] d);
        rx.c0.mmioRdValid = rd;
        rx.c0.mmioWrValid = wr;
        rx.c0.hdr.address = a;
        rx.c0.hdr.length  = l;
        rx.c0.hdr.tid     = t;
        rx.c0.data        = d;
    endtask

    task automatic mmio_write(input logic [15:0] a, input logic [1:0] l, input logic [63:0] d);
        drive(1'b1 ^ 1'b1, 1'b1, a, l, 9'h0, d);
        tick();
        rx = '0;
    endtask

    task automatic mmio_read(input logic [15:0] a, input logic [1:0] l, input logic [8:0] t,
                             input logic [63:0] exp, input string nm);
        drive(1'b1, 1'b0, a, l, t, 64'h0);
        tick();
        rx = '0;
        chk({nm, " vld@1"}, 64'(tx.mmioRdValid), 64'd0);
        tick();
        chk({nm, " vld@2"}, 64'(tx.mmioRdValid), 64'd1);
        chk({nm, " tid"}, 64'(tx.hdr.tid), 64'(t));
        chk({nm, " data"}, tx.data, exp);
        tick();
        chk({nm, " vld@3"}, 64'(tx.mmioRdValid), 64'd0);
        chk({nm, " idle data"}, tx.data, 64'd0);
    endtask

    initial begin
        rx         = '0;
        hw_wr_en   = 1'b0;
        hw_wr_idx  = '0;
        hw_wr_data = '0;
        SoftReset  = 1'b1;

        vecs.push_back('{1'b0, 16'h0000, LEN_8B, 9'h005, DFH});
        vecs.push_back('{1'b0, 16'h0002, LEN_8B, 9'h007, IDL});
        vecs.push_back('{1'b0, 16'h0005, LEN_4B, 9'h008, 64'h0000_0000_FEDC_BA98});
        vecs.push_back('{1'b1, 16'h0008, LEN_8B, 9'h000, 64'hDEAD_BEEF_0123_4567});
        vecs.push_back('{1'b0, 16'h0008, LEN_4B, 9'h011, 64'h0000_0000_0123_4567});
        vecs.push_back('{1'b0, 16'h0009, LEN_4B, 9'h012, 64'h0000_0000_DEAD_BEEF});
        vecs.push_back('{1'b0, 16'h0008, LEN_8B, 9'h013, 64'hDEAD_BEEF_0123_4567});
        vecs.push_back('{1'b1, 16'h000B, LEN_4B, 9'h000, 64'h1234_5678_AAAA_5555});
        vecs.push_back('{1'b0, 16'h000A, LEN_8B, 9'h014, 64'hAAAA_5555_0000_0000});
        vecs.push_back('{1'b1, 16'h000A, LEN_4B, 9'h000, 64'h0000_0000_0F0F_0F0F});
        vecs.push_back('{1'b0, 16'h000A, LEN_8B, 9'h015, 64'hAAAA_5555_0F0F_0F0F});
        vecs.push_back('{1'b1, 16'h0000, LEN_8B, 9'h000, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{1'b0, 16'h0000, LEN_8B, 9'h016, DFH});
        vecs.push_back('{1'b0, 16'h0006, LEN_8B, 9'h017, 64'h0});
        vecs.push_back('{1'b0, 16'h0040, LEN_8B, 9'h1FF, 64'h0});
        vecs.push_back('{1'b0, 16'h0005, LEN_8B, 9'h018, 64'h0});
        vecs.push_back('{1'b0, 16'h0006, LEN_8B, 9'h019, 64'h0000_0000_0001_0001});
        vecs.push_back('{1'b0, 16'h0008, LEN_64B, 9'h01A, 64'h0});
        vecs.push_back('{1'b1, 16'h0009, LEN_8B, 9'h000, 64'h1111_2222_3333_4444});
        vecs.push_back('{1'b0, 16'h0008, LEN_8B, 9'h01B, 64'hDEAD_BEEF_0123_4567});
        vecs.push_back('{1'b0, 16'h0006, LEN_8B, 9'h01C, 64'h0000_0000_0001_0003});
        vecs.push_back('{1'b1, 16'h0006, LEN_4B, 9'h000, 64'h0});
        vecs.push_back('{1'b0, 16'h0006, LEN_8B, 9'h01D, 64'h0});
        vecs.push_back('{1'b1, 16'h001E, LEN_8B, 9'h000, 64'h5A5A_A5A5_C3C3_3C3C});
        vecs.push_back('{1'b0, 16'h001F, LEN_4B, 9'h01E, 64'h0000_0000_5A5A_A5A5});
        vecs.push_back('{1'b0, 16'h0020, LEN_8B, 9'h01F, 64'h0});
        vecs.push_back('{1'b0, 16'h0006, LEN_8B, 9'h020, 64'h0000_0000_0001_0000});

        repeat (3) tick();
        SoftReset = 1'b0;
        chk("reset vld", 64'(tx.mmioRdValid), 64'd0);
        chk("reset tid", 64'(tx.hdr.tid), 64'd0);
        chk("reset data", tx.data, 64'd0);
        chk("reset csr4", csr(4), 64'd0);
        chk("reset err", csr(3), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr)
                mmio_write(vecs[i].addr, vecs[i].len, vecs[i].data);
            else
                mmio_read(vecs[i].addr, vecs[i].len, vecs[i].tid, vecs[i].data, $sformatf("vec%0d", i));
        end

        // Back-to-back reads, tids 1..3, responses expected in cycles 2..4.
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("b2b c%0d vld", c), 64'(tx.mmioRdValid), 64'((c >= 2 && c <= 4) ? 1 : 0));
            if (c >= 2 && c <= 4) begin
                chk($sformatf("b2b c%0d tid", c), 64'(tx.hdr.tid), 64'(c - 1));
                chk($sformatf("b2b c%0d data", c), tx.data, 64'hDEAD_BEEF_0123_4567);
            end
            if (c < 3) drive(1'b1, 1'b0, 16'h0008, LEN_8B, 9'(c + 1), 64'h0);
            else       rx = '0;
            tick();
        end

        // Same-cycle hw and MMIO writes to CSR 5, hw-only writes elsewhere.
        hw_wr_en = 1'b1; hw_wr_idx = 6'd5; hw_wr_data = 64'h11;
        drive(1'b0, 1'b1, 16'h000A, LEN_8B, 9'h0, 64'h22);
        tick();
        rx = '0;
        hw_wr_idx = 6'd6; hw_wr_data = 64'h33;
        tick();
        chk("arb csr5", csr(5), 64'h22);
        hw_wr_idx = 6'd2; hw_wr_data = 64'h99;
        tick();
        chk("hw csr6", csr(6), 64'h33);
        hw_wr_idx = 6'd3; hw_wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        chk("hw ro csr2", csr(2), IDH);
        hw_wr_en = 1'b0;
        tick();
        chk("hw ro err", csr(3), 64'h0000_0000_0001_0000);

        // Read and write together: no access, no response, sticky flag.
        drive(1'b1, 1'b1, 16'h000C, LEN_8B, 9'h044, 64'hFF);
        tick();
        rx = '0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("proto c%0d vld", c), 64'(tx.mmioRdValid), 64'd0);
            tick();
        end
        chk("proto csr6", csr(6), 64'h33);
        chk("proto err", csr(3), 64'h0000_0001_0001_0000);

        // Read in flight when SoftReset arrives must vanish.
        drive(1'b1, 1'b0, 16'h0008, LEN_8B, 9'h055, 64'h0);
        tick();
        rx = '0;
        SoftReset = 1'b1;
        tick();
        SoftReset = 1'b0;
        chk("rst drop c0", 64'(tx.mmioRdValid), 64'd0);
        tick();
        chk("rst drop c1", 64'(tx.mmioRdValid), 64'd0);
        chk("rst csr4", csr(4), 64'd0);
        chk("rst err", csr(3), 64'd0);
        mmio_read(16'h0008, LEN_8B, 9'h066, 64'h0, "post-rst csr4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
